// File: rtl/reg_slice_skid_rst_pkg.sv
// reg_slice_skid_rst_pkg: shared types and constants for the skid register slice
package reg_slice_skid_rst_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} slice_state_t;
  localparam int LEVEL_W = 2;
endpackage

// File: rtl/reg_ce_rst.sv
// reg_ce_rst: data register with clock enable and synchronous active-high reset
module reg_ce_rst #(
  parameter int width = 16,
  parameter logic [width-1:0] init = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);
  // reset wins over enable; otherwise load only when enabled
  always_ff @(posedge clk)
    if (rst) q_o <= init;
    else if (ce_i) q_o <= d_i;
endmodule

// File: rtl/reg_slice_skid_rst.sv
// reg_slice_skid_rst: two-entry main+skid elastic register slice with registered handshake outputs
module reg_slice_skid_rst
  import reg_slice_skid_rst_pkg::*;
#(
  parameter int width = 16,
  parameter logic [width-1:0] init = '0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [width-1:0]   I_data,
  input  logic               I_valid,
  output logic               I_ready,
  output logic [width-1:0]   O_data,
  output logic               O_valid,
  input  logic               O_ready,
  output logic [LEVEL_W-1:0] level
);
  slice_state_t state_q, state_d;
  logic in_fire, out_fire, load_main, load_skid;
  logic [width-1:0] main_d, main_q, skid_q;
  // handshake outputs decode the state register only, so O_ready never reaches I_ready
  always_comb begin
    O_valid = (state_q == ONE) || (state_q == FULL);
    I_ready = state_q != FULL;
    level = state_q == FULL ? 2'd2 : state_q == ONE ? 2'd1 : 2'd0;
    O_data = main_q;
  end
  // load-enable decode: main takes the input or, when draining FULL, the older skid word
  always_comb begin
    in_fire = I_valid & I_ready;
    out_fire = O_valid & O_ready;
    load_main = (state_q == EMPTY && in_fire) || (state_q == ONE && in_fire && out_fire) || (state_q == FULL && out_fire);
    load_skid = state_q == ONE && in_fire && !out_fire;
    main_d = state_q == FULL ? skid_q : I_data;
  end
  // next-state; the unused encoding falls back to EMPTY
  always_comb begin
    state_d = state_q == EMPTY ? (in_fire ? ONE : EMPTY)
            : state_q == ONE   ? (in_fire == out_fire ? ONE : in_fire ? FULL : EMPTY)
            : state_q == FULL  ? (out_fire ? ONE : FULL)
            : EMPTY;
  end
  // occupancy state register
  always_ff @(posedge CLK)
    if (RESET) state_q <= EMPTY;
    else state_q <= state_d;
  reg_ce_rst #(.width(width), .init(init)) u_main (
    .clk(CLK), .rst(RESET), .ce_i(load_main), .d_i(main_d), .q_o(main_q)
  );
  reg_ce_rst #(.width(width), .init(init)) u_skid (
    .clk(CLK), .rst(RESET), .ce_i(load_skid), .d_i(I_data), .q_o(skid_q)
  );
endmodule

// File: tb/tb_reg_slice_skid_rst.sv
// tb_reg_slice_skid_rst: directed and random checks of the skid slice against a queue model
module tb_reg_slice_skid_rst;
  localparam int W = 16;
  localparam logic [W-1:0] INIT = 16'h0000;
  logic CLK = 1'b0;
  logic RESET, I_valid, I_ready, O_valid, O_ready;
  logic [W-1:0] I_data, O_data;
  logic [1:0] level;
  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  logic [W-1:0] q[$];
  logic [W-1:0] held = INIT;

  reg_slice_skid_rst #(.width(W), .init(INIT)) dut (
    .CLK(CLK), .RESET(RESET), .I_data(I_data), .I_valid(I_valid), .I_ready(I_ready),
    .O_data(O_data), .O_valid(O_valid), .O_ready(O_ready), .level(level)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a FIFO of at most two words; the visible word is the oldest one, or the last one shown
  always @(posedge CLK) begin
    bit inf, outf;
    if (RESET) begin
      q.delete();
      held = INIT;
    end else begin
      inf = I_valid && q.size() < 2;
      outf = O_ready && q.size() > 0;
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(I_data);
      if (q.size() > 0) held = q[0];
    end
  end

  always @(negedge CLK)
    if (check_en) begin
      chk("m_valid", 32'(O_valid), 32'(q.size() != 0));
      chk("m_level", 32'(level), 32'(q.size()));
      chk("m_ready", 32'(I_ready), 32'(q.size() < 2));
      chk("m_data", 32'(O_data), 32'(held));
    end

  task automatic cyc(input logic rst, input logic v, input logic [W-1:0] d, input logic r);
    RESET = rst; I_valid = v; I_data = d; O_ready = r;
    @(posedge CLK); #1;
  endtask

  task automatic look(input string tag, input logic v, input logic [1:0] lv, input logic ir, input logic [W-1:0] d);
    chk({tag, "_valid"}, 32'(O_valid), 32'(v));
    chk({tag, "_level"}, 32'(level), 32'(lv));
    chk({tag, "_ready"}, 32'(I_ready), 32'(ir));
    chk({tag, "_data"}, 32'(O_data), 32'(d));
  endtask

  initial begin
    cyc(1, 1, 16'hBEEF, 0);
    check_en = 1'b1;
    cyc(1, 1, 16'hBEEF, 0);
    look("rst", 0, 0, 1, 16'h0000);
    cyc(0, 0, 16'hBEEF, 0);
    look("rel", 0, 0, 1, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, W'(i), 1);
      look("stream", 1, 1, 1, W'(i));
    end
    cyc(0, 0, 16'h0000, 1);
    look("stream_end", 0, 0, 1, 16'h0008);
    cyc(0, 1, 16'hAAAA, 0);
    look("fill1", 1, 1, 1, 16'hAAAA);
    cyc(0, 1, 16'h5555, 0);
    look("fill2", 1, 2, 0, 16'hAAAA);
    cyc(0, 1, 16'h1234, 0);
    look("blocked", 1, 2, 0, 16'hAAAA);
    cyc(0, 0, 16'h1234, 1);
    look("drain1", 1, 1, 1, 16'h5555);
    cyc(0, 0, 16'h1234, 1);
    look("drain2", 0, 0, 1, 16'h5555);
    cyc(0, 1, 16'h0010, 0);
    look("one", 1, 1, 1, 16'h0010);
    cyc(0, 1, 16'h0020, 1);
    look("simul", 1, 1, 1, 16'h0020);
    cyc(0, 1, 16'h0030, 0);
    look("full", 1, 2, 0, 16'h0020);
    cyc(1, 1, 16'h0040, 1);
    look("midrst", 0, 0, 1, INIT);
    cyc(0, 0, 16'h0040, 1);
    look("post_rst", 0, 0, 1, INIT);
    for (int i = 0; i < 400; i++)
      cyc(0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1)) : 1'b0));
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0000, 1);
    look("final", 0, 0, 1, held);
    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_slice_skid_rst.md
Name: reg_slice_skid_rst

Overview:
- Elastic pipeline register slice: the flow-controlled counterpart of the plain clock-enable register.
- Upstream pushes words with a valid/ready handshake. Downstream backpressure stalls the slice without dropping data.
- A 2-entry main+skid structure gives full throughput and fully registered outputs, with no combinational path from O_ready to I_ready.
- Sits between generated datapath stages wherever a stage must be able to stall.

Parameters:
- width, 16, data word width in bits (>=1).
- init, 0, reset value of the main and skid data registers (width bits).

Ports:
- CLK  in  1  rising-edge clock, the only clock.
- RESET  in  1  reset, synchronous and active-high.
- I_data  in  width  upstream data word.
- I_valid  in  1  upstream word present.
- I_ready  out  1  slice can accept a word this cycle.
- O_data  out  width  downstream data word (main register).
- O_valid  out  1  O_data holds a valid word.
- O_ready  in  1  downstream accepts O_data this cycle.
- level  out  2  occupancy: 0, 1 or 2 words held.

Behaviour:
- Reset (RESET high at a CLK edge):
  - state <= EMPTY; main and skid data <= init.
  - After that edge: O_valid=0, level=0, O_data=init, I_ready=1.
  - While RESET is high, transfers are ignored in both directions. RESET overrides any simultaneous handshake, including mid-operation, and held words are discarded.
- Transfers:
  - in_fire = I_valid & I_ready.
  - out_fire = O_valid & O_ready.
  - Both are sampled at the CLK edge.
- Outputs:
  - O_valid = (state != EMPTY).
  - I_ready = (state != FULL).
  - level = 0 / 1 / 2 for EMPTY / ONE / FULL.
  - All outputs are decoded from registers only; there are no input-to-output combinational paths.
- State transitions (EMPTY/ONE/FULL):
  - EMPTY:
    - in_fire: main <= I_data, go to ONE.
    - Otherwise stay.
  - ONE:
    - in_fire & out_fire: main <= I_data, stay ONE (full-rate streaming).
    - in_fire only: skid <= I_data, go to FULL.
    - out_fire only: go to EMPTY.
    - Neither: hold.
  - FULL (I_ready=0, in_fire is impossible):
    - out_fire: main <= skid, go to ONE.
    - Otherwise hold both registers.
- Latency: a word accepted at edge N is visible on O_data/O_valid after edge N (one cycle). Sustained throughput is 1 word/cycle when O_ready is held high.
- Ordering: strict FIFO; the skid word is always older than any later input.
- Stability: while O_valid=1 and O_ready=0, O_data is held stable, and neither data register changes unless loaded as described above.
- Unheld data: the data registers retain their last value when not loaded. O_data is don't-care while O_valid=0 but shall equal the last held value (deterministic, for equivalence checks).
- Inputs while not ready: I_valid=1 with I_ready=0 has no effect. Upstream must hold the word.

Decomposition:
- Shared package:
  - slice_state_t enum {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}; 2'd3 is unreachable and recovers to EMPTY.
  - Localparam LEVEL_W=2.
- Sub-module reg_ce_rst(width, init): data register with clock enable and synchronous active-high reset. Instantiate it twice, once for main (CE = main load) and once for skid (CE = skid load).
- The FSM and load-enable decode live in the top.

Test Plan:
- Reset: hold RESET 2 cycles with I_valid=1, I_data=16'hBEEF -> O_valid=0, level=0, O_data=16'h0000, I_ready=1 after release; nothing captured.
- Streaming: O_ready=1, push 16'h0001..16'h0008 on consecutive cycles -> each word appears one cycle later, in order, no bubbles, level stays 1, I_ready never drops.
- Backpressure fill: O_ready=0, push 16'hAAAA then 16'h5555 -> level 1 then 2, I_ready=0 after the second push, O_data=16'hAAAA held; a third word offered (16'h1234) is not accepted.
- Drain from FULL: from the previous state, raise O_ready for 2 cycles -> O_data 16'hAAAA then 16'h5555, level 2->1->0, I_ready=1 after the first drain.
- Simultaneous in/out in ONE: main=16'h0010, offer 16'h0020 with O_ready=1 -> next cycle O_data=16'h0020, level=1.
- Mid-operation reset: in FULL, assert RESET with O_ready=1 and I_valid=1 -> next cycle EMPTY, both data registers = init, no word delivered. Also run randomized valid/ready against a reference queue: no loss, no duplication, order preserved.
